// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu
//  Description : Execute-stage arithmetic unit. Single-cycle ALU with a
//                registered result and flags, plus an iterative shift-add
//                multiplier / restoring divider writing HI/LO. A
//                start/busy/done handshake lets the pipeline stall on
//                multi-cycle operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    // Shift-amount width; derived from WIDTH and not meant to be overridden.
    localparam int SHW = $clog2(WIDTH);

    // Iteration index of the final multiply/divide step.
    localparam logic [SHW-1:0] c_last_iter = SHW'(WIDTH - 1);

    // ALU operation codes
    localparam logic [4:0] c_op_add  = 5'h00;
    localparam logic [4:0] c_op_addu = 5'h01;
    localparam logic [4:0] c_op_sub  = 5'h02;
    localparam logic [4:0] c_op_subu = 5'h03;
    localparam logic [4:0] c_op_and  = 5'h04;
    localparam logic [4:0] c_op_or   = 5'h05;
    localparam logic [4:0] c_op_xor  = 5'h06;
    localparam logic [4:0] c_op_nor  = 5'h07;
    localparam logic [4:0] c_op_slt  = 5'h08;
    localparam logic [4:0] c_op_sltu = 5'h09;
    localparam logic [4:0] c_op_sll  = 5'h0A;
    localparam logic [4:0] c_op_srl  = 5'h0B;
    localparam logic [4:0] c_op_sra  = 5'h0C;
    localparam logic [4:0] c_op_lui  = 5'h0D;

    // Handshake FSM encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;

    logic               w_accept;
    logic               w_is_mdu;
    logic               w_div0;
    logic               w_go_calc;
    logic               w_last;

    logic [SHW-1:0]     w_sh;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_sll;
    logic [WIDTH:0]     w_srl;
    logic [WIDTH:0]     w_sra;
    logic [WIDTH-1:0]   w_y;
    logic               w_c;
    logic               w_v;

    logic               w_sgn_a;
    logic               w_sgn_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_mag_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [SHW-1:0]     r_cnt;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_hi_fin;
    logic [WIDTH-1:0]   w_lo_fin;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    // MDU codes are 0x10..0x13; op[1] selects divide, op[0] selects unsigned.
    assign w_is_mdu  = (op[4:2] == 3'b100);
    assign w_div0    = w_is_mdu && op[1] && (B == '0);
    assign w_accept  = start && (r_state != c_st_calc);
    assign w_go_calc = w_accept && w_is_mdu && !w_div0;
    assign w_last    = (r_state == c_st_calc) && (r_cnt == c_last_iter);

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    // State register; reset forces IDLE and aborts any running iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; DONE accepts a new request so ALU ops can stream.
    always_comb begin
        w_state_nx = c_st_idle;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (w_accept) begin
                    w_state_nx = w_go_calc ? c_st_calc : c_st_done;
                end else begin
                    w_state_nx = c_st_idle;
                end
            end
            c_st_calc: begin
                w_state_nx = w_last ? c_st_done : c_st_calc;
            end
            default: begin
                w_state_nx = c_st_idle;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        busy = (r_state == c_st_calc);
        done = (r_state == c_st_done);
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    assign w_sh  = A[SHW-1:0];
    assign w_add = {1'b0, A} + {1'b0, B};
    // Top bit of the widened difference is the unsigned borrow (A < B).
    assign w_sub = {1'b0, A} - {1'b0, B};
    // The extra bit on each shifter catches the last bit shifted out; it
    // stays 0 for a zero shift amount.
    assign w_sll = {1'b0, B} << w_sh;
    assign w_srl = {B, 1'b0} >> w_sh;
    assign w_sra = $unsigned($signed({B, 1'b0}) >>> w_sh);

    // Result, carry and overflow for the current op; illegal codes yield 0.
    always_comb begin
        w_y = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (op)
            c_op_add: begin
                w_y = w_add[WIDTH-1:0];
                w_c = w_add[WIDTH];
                w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
            end
            c_op_addu: begin
                w_y = w_add[WIDTH-1:0];
                w_c = w_add[WIDTH];
            end
            c_op_sub: begin
                w_y = w_sub[WIDTH-1:0];
                w_c = w_sub[WIDTH];
                w_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            c_op_subu: begin
                w_y = w_sub[WIDTH-1:0];
                w_c = w_sub[WIDTH];
            end
            c_op_and:  w_y = A & B;
            c_op_or:   w_y = A | B;
            c_op_xor:  w_y = A ^ B;
            c_op_nor:  w_y = ~(A | B);
            c_op_slt:  w_y = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            c_op_sltu: w_y = {{(WIDTH-1){1'b0}}, (A < B)};
            c_op_sll: begin
                w_y = w_sll[WIDTH-1:0];
                w_c = w_sll[WIDTH];
            end
            c_op_srl: begin
                w_y = w_srl[WIDTH:1];
                w_c = w_srl[0];
            end
            c_op_sra: begin
                w_y = w_sra[WIDTH:1];
                w_c = w_sra[0];
            end
            c_op_lui:  w_y = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: begin
                w_y = '0;
            end
        endcase
    end

    // ALU result and flags land on the accept edge; MDU ops leave them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y        <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (w_accept && !w_is_mdu) begin
            Y        <= w_y;
            zero     <= (w_y == '0);
            carry    <= w_c;
            negative <= w_y[WIDTH-1];
            overflow <= w_v;
        end
    end

    // ------------------------------------------------------------------
    // Iterative multiply / divide engine
    // ------------------------------------------------------------------
    // The engine works on magnitudes; signs are applied once at the end.
    assign w_sgn_a = !op[0] && A[WIDTH-1];
    assign w_sgn_b = !op[0] && B[WIDTH-1];
    assign w_mag_a = w_sgn_a ? -A : A;
    assign w_mag_b = w_sgn_b ? -B : B;

    // Multiply step: conditionally add the multiplicand to the high half,
    // then shift {acc, q} right; q starts as the multiplier and fills with
    // the low product bits.
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mag_b} : '0);

    // Divide step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. The remainder never reaches
    // the divisor, so the low WIDTH bits of the difference are exact.
    assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_mag_b});
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_mag_b;

    // One iteration of whichever algorithm is running.
    always_comb begin
        w_acc_nx = r_acc;
        w_q_nx   = r_q;
        if (r_is_div) begin
            w_acc_nx = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
            w_q_nx   = {r_q[WIDTH-2:0], w_div_ge};
        end else begin
            {w_acc_nx, w_q_nx} = {w_mul_sum, r_q[WIDTH-1:1]};
        end
    end

    // Sign correction on the final iteration's result. Signed MIN / -1
    // wraps back to MIN with a zero remainder without special handling.
    assign w_prod_fix = r_neg_q ? -{w_acc_nx, w_q_nx} : {w_acc_nx, w_q_nx};

    // Select the corrected HI/LO values for the running operation.
    always_comb begin
        w_hi_fin = '0;
        w_lo_fin = '0;
        if (r_is_div) begin
            w_hi_fin = r_neg_r ? -w_acc_nx : w_acc_nx;
            w_lo_fin = r_neg_q ? -w_q_nx : w_q_nx;
        end else begin
            {w_hi_fin, w_lo_fin} = w_prod_fix;
        end
    end

    // Operand capture at accept, then one iteration per clock in CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
        end else if (w_go_calc) begin
            r_is_div <= op[1];
            r_neg_q  <= w_sgn_a ^ w_sgn_b;
            r_neg_r  <= w_sgn_a;
            r_mag_b  <= w_mag_b;
            r_acc    <= '0;
            r_q      <= w_mag_a;
            r_cnt    <= '0;
        end else if (r_state == c_st_calc) begin
            r_acc    <= w_acc_nx;
            r_q      <= w_q_nx;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // HI/LO: divide-by-zero writes at accept, iterative ops on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (w_accept && w_div0) begin
            hi <= A;
            lo <= '1;
        end else if (w_last) begin
            hi <= w_hi_fin;
            lo <= w_lo_fin;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mdu
//  Description : Self-checking bench for alu_mdu: directed vector table,
//                hand-written multi-cycle sequences and randomized ops
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    op;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic [W-1:0]  y;
    logic          zero;
    logic          carry;
    logic          negative;
    logic          overflow;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic [3:0]    flags;

    assign flags = {zero, carry, negative, overflow};

    int checks = 0;
    int errors = 0;

    // Reference-model view of the architectural registers
    logic [W-1:0]  m_y;
    logic [3:0]    m_f;
    logic [W-1:0]  m_hi;
    logic [W-1:0]  m_lo;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [3:0]  f;   // {zero, carry, negative, overflow}
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .A        (a_in),
        .B        (b_in),
        .Y        (y),
        .zero     (zero),
        .carry    (carry),
        .negative (negative),
        .overflow (overflow),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check($sformatf("%s_y", tag), y, m_y);
        check($sformatf("%s_flags", tag), flags, m_f);
        check($sformatf("%s_hi", tag), hi, m_hi);
        check($sformatf("%s_lo", tag), lo, m_lo);
    endtask

    // ALU reference: plain wide arithmetic on the operand values
    function automatic void model_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] yy, output logic [3:0] ff);
        longint ua, ub, sa, sb, r;
        int     sh;
        logic   c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a[4:0]);
        yy = '0;
        c  = 1'b0;
        v  = 1'b0;
        case (o)
            5'h00, 5'h01: begin
                r  = ua + ub;
                yy = r[31:0];
                c  = (r > 64'sh0FFFF_FFFF);
                if (o == 5'h00) v = ((sa + sb) > SMAX) || ((sa + sb) < SMIN);
            end
            5'h02, 5'h03: begin
                r  = ua - ub;
                yy = r[31:0];
                c  = (ua < ub);
                if (o == 5'h02) v = ((sa - sb) > SMAX) || ((sa - sb) < SMIN);
            end
            5'h04: yy = a & b;
            5'h05: yy = a | b;
            5'h06: yy = a ^ b;
            5'h07: yy = ~(a | b);
            5'h08: yy = (sa < sb) ? 32'd1 : 32'd0;
            5'h09: yy = (ua < ub) ? 32'd1 : 32'd0;
            5'h0A: begin
                r  = ub << sh;
                yy = r[31:0];
                c  = (sh != 0) && r[32];
            end
            5'h0B, 5'h0C: begin
                r  = (o == 5'h0B) ? (ub >> sh) : (sb >>> sh);
                yy = r[31:0];
                if (sh != 0) begin
                    r = ub >> (sh - 1);
                    c = r[0];
                end
            end
            5'h0D: yy = b << 16;
            default: yy = '0;
        endcase
        ff = {(yy == 32'd0), c, yy[31], v};
    endfunction

    // MDU reference: 64-bit products and language-level division
    function automatic void model_mdu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l);
        longint ua, ub, sa, sb, q, r;
        logic [63:0] p;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            5'h10: p = sa * sb;
            5'h11: p = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = (o == 5'h12) ? (sa / sb) : (ua / ub);
                    r = (o == 5'h12) ? (sa % sb) : (ua % ub);
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    task automatic run_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        model_alu(o, a, b, m_y, m_f);
        op = o; a_in = a; b_in = b; start = 1'b1;
        tick();
        start = 1'b0;
        check("alu_done", done, 1);
        check("alu_busy", busy, 0);
        check_state("alu");
    endtask

    // Runs one MDU op; while busy the inputs are scrambled and, with poke,
    // a competing ADD request is raised that must be ignored.
    task automatic run_mdu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
        int n;
        int exp_n;
        logic [31:0] eh, el;
        model_mdu(o, a, b, eh, el);
        exp_n = (o[1] && b == 32'd0) ? 0 : W;
        op = o; a_in = a; b_in = b; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            if (poke && n == 5) begin
                start = 1'b1; op = 5'h00; a_in = 32'h1111; b_in = 32'h2222;
            end else begin
                start = 1'b0; op = 5'($urandom_range(0, 31));
                a_in = $urandom; b_in = $urandom;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("mdu_busy_cycles", n, exp_n);
        check("mdu_done", done, 1);
        m_hi = eh;
        m_lo = el;
        check_state("mdu");
        tick();
        check("mdu_done_drop", done, 0);
        check("mdu_busy_after", busy, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] pool [5];
        pool[0] = 32'h0;
        pool[1] = 32'h1;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 5) == 0) return pool[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        vecs[0]  = '{5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011};
        vecs[1]  = '{5'h03, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0110};
        vecs[2]  = '{5'h0C, 32'h0000_0004, 32'h8000_0010, 32'hF800_0001, 4'b0010};
        vecs[3]  = '{5'h0B, 32'h0000_0021, 32'h0000_0003, 32'h0000_0001, 4'b0100};
        vecs[4]  = '{5'h0D, 32'h0000_0000, 32'hABCD_1234, 32'h1234_0000, 4'b0000};
        vecs[5]  = '{5'h01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100};
        vecs[6]  = '{5'h02, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001};
        vecs[7]  = '{5'h08, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000};
        vecs[8]  = '{5'h09, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000};
        vecs[9]  = '{5'h04, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0010};
        vecs[10] = '{5'h07, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0010};
        vecs[11] = '{5'h06, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 4'b1000};
        vecs[12] = '{5'h05, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000};
        vecs[13] = '{5'h0A, 32'hFFFF_FFE0, 32'h8000_0001, 32'h8000_0001, 4'b0010};
        vecs[14] = '{5'h0A, 32'h0000_0001, 32'h8000_0001, 32'h0000_0002, 4'b0100};
        vecs[15] = '{5'h0E, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1000};
        vecs[16] = '{5'h1F, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 4'b1000};
        vecs[17] = '{5'h0C, 32'h0000_001F, 32'h4000_0000, 32'h0000_0000, 4'b1100};
        vecs[18] = '{5'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0110};
        vecs[19] = '{5'h02, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1000};

        // Reset state
        rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        tick();
        tick();
        rst = 1'b0;
        m_y = '0; m_f = '0; m_hi = '0; m_lo = '0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_state("rst");

        // Directed table, issued back-to-back with start held high
        for (int i = 0; i < NV; i++) begin
            op = vecs[i].op; a_in = vecs[i].a; b_in = vecs[i].b; start = 1'b1;
            tick();
            check($sformatf("vec%0d_done", i), done, 1);
            check($sformatf("vec%0d_y", i), y, vecs[i].y);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].f);
        end
        start = 1'b0;
        m_y = vecs[NV-1].y;
        m_f = vecs[NV-1].f;
        check("vec_hi_untouched", hi, 0);
        check("vec_lo_untouched", lo, 0);
        tick();
        check("vec_done_drop", done, 0);

        // Signed multiply with an ignored mid-CALC start
        run_mdu(5'h10, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        // Divide corner cases
        run_mdu(5'h12, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_mdu(5'h12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("div_min_lo", lo, 32'h8000_0000);
        check("div_min_hi", hi, 32'h0);
        run_mdu(5'h13, 32'h0000_0005, 32'h0000_0000, 1'b0);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'h5);

        // Reset in the middle of an iterative multiply
        run_alu(5'h01, 32'h0000_1000, 32'h0000_0234);
        op = 5'h11; a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_y = '0; m_f = '0; m_hi = '0; m_lo = '0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check_state("abort");
        tick();
        check("abort_hold_hi", hi, 0);
        run_alu(5'h00, 32'h0000_0002, 32'h0000_0003);
        check("abort_add_y", y, 32'h5);
        run_mdu(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  o;
            logic [31:0] a, b;
            o = 5'($urandom_range(0, 31));
            a = pick_operand();
            b = pick_operand();
            if (o >= 5'h10 && o <= 5'h13) begin
                if (o[1] && $urandom_range(0, 5) == 0) b = 32'h0;
                run_mdu(o, a, b, ($urandom_range(0, 3) == 0));
            end else begin
                run_alu(o, a, b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage arithmetic unit for the CPU datapath. It performs all single-cycle ALU operations on `WIDTH`-bit operands with a registered result and proper status flags. It adds an iterative multiply/divide engine (signed/unsigned) writing HI/LO registers. A start/busy/done handshake lets the pipeline stall on multi-cycle operations.

## Interface
- `WIDTH`, 32, operand/result width; power of two, at least 8.
- `SHW`, $clog2(WIDTH), shift-amount width (derived; do not override).

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  request; accepted on an edge where `start=1` and `busy=0`.
- `op`  in  5  operation code, sampled at accept.
- `A`  in  WIDTH  operand A; shift amount for shifts. Sampled at accept.
- `B`  in  WIDTH  operand B, sampled at accept.
- `Y`  out  WIDTH  registered ALU result.
- `zero`, `carry`, `negative`, `overflow`  out  1 each  registered flags for `Y`.
- `hi`, `lo`  out  WIDTH each  registered multiply/divide results.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: the result of the accepted operation is valid.

## Operation
- **ALU codes:** 0x00 ADD, 0x01 ADDU, 0x02 SUB, 0x03 SUBU, 0x04 AND, 0x05 OR, 0x06 XOR, 0x07 NOR, 0x08 SLT, 0x09 SLTU, 0x0A SLL, 0x0B SRL, 0x0C SRA, 0x0D LUI.
- **MDU codes:** 0x10 MULT, 0x11 MULTU, 0x12 DIV, 0x13 DIVU.
- **Illegal codes:** any other code is treated as an ALU op with `Y=0`, `zero=1` and the other flags 0.
- **Shifts:** shift amount = `A[SHW-1:0]`; upper bits of `A` are ignored. SLL is `B<<sh`, SRL is a logical right shift of B, SRA is an arithmetic right shift of B.
- **SLT/SLTU:** `Y` = 1 or 0.
- **LUI:** `Y = {B[WIDTH/2-1:0], WIDTH/2 zeros}`.
- **Flags (ALU ops only):**
  - `zero = (Y==0)`; `negative = Y[WIDTH-1]`.
  - ADD/ADDU: `carry` = unsigned carry-out.
  - SUB/SUBU: `carry` = unsigned borrow (`A<B` unsigned).
  - ADD and SUB: `overflow` = two's-complement overflow. ADDU/SUBU: `overflow=0`.
  - SLL/SRL/SRA: `carry` = last bit shifted out, or 0 when shift amount is 0; `overflow=0`.
  - All other ops: `carry=0`, `overflow=0`.
- **Register ownership:** ALU ops update `Y` and the flags only. MDU ops update `hi`/`lo` only. Each register set holds its value otherwise.
- **Multiply:** shift-add over operand magnitudes, one iteration per cycle, `WIDTH` iterations. Signed ops apply sign correction to the 2·WIDTH product. Result `{hi,lo}` = full product.
- **Divide:** restoring, on magnitudes, `WIDTH` iterations.
  - `lo` = quotient truncated toward zero; `hi` = remainder with the sign of A.
  - Signed MIN/−1 gives `lo=MIN`, `hi=0`.
  - Divide by zero (B==0, DIV or DIVU): `lo` = all ones, `hi` = A. Takes the single-cycle path with no iterations.
- **Operand capture:** operands and op are latched at accept; input changes while busy are ignored.
- **FSM states:** IDLE, CALC, DONE.
  - IDLE/DONE + accept of an ALU op or divide-by-zero → DONE; `Y`/flags or `hi`/`lo` are written on the accept edge.
  - IDLE/DONE + accept of a multiply or nonzero divide → CALC; iteration counter cleared.
  - CALC: one iteration per edge. After the `WIDTH`-th iteration edge → DONE, with corrected `hi`/`lo` written on that edge.
  - DONE with no accept → IDLE.
- **Handshake outputs:** `busy=1` only in CALC. `done=1` only in DONE.

## Timing
- **Reset:** `rst` high at an edge forces IDLE. On that edge `Y`, `hi`, `lo`, all flags, `busy` and `done` become 0, and the iteration counter clears.
- **Reset priority:** reset overrides `start` and aborts CALC mid-operation with no partial `hi`/`lo` write.
- **ALU op latency:** accept at edge e0 → `done=1` during the cycle after e0, with `Y`/flags valid.
- **MDU latency:** accept at e0 → `busy=1` for exactly `WIDTH` cycles (e0 to e_WIDTH) → `done=1` for one cycle after e_WIDTH, with `hi`/`lo` valid.
- **Start while busy:** ignored entirely, with no queuing.
- **Back-to-back:** `start` is accepted in a DONE cycle, giving back-to-back ALU ops at one per cycle with `done` continuously high.
- **Done width:** `done` is never high for more than one cycle per accepted operation.

## Test plan
- **ADD overflow:** ADD A=0x7FFFFFFF, B=1 → next cycle `done=1`, `Y=0x80000000`, `overflow=1`, `carry=0`, `negative=1`, `zero=0`.
- **SUBU borrow:** SUBU A=0, B=1 → `Y=0xFFFFFFFF`, `carry=1`, `overflow=0`.
- **Shifts:**
  - SRA A=4, B=0x80000010 → `Y=0xF8000001`, `carry=0`.
  - SRL A=0x21 (sh=1), B=3 → `Y=1`, `carry=1`.
  - LUI B=0x1234 → `Y=0x12340000`.
- **Signed multiply:** MULT A=0xFFFFFFFD, B=7 → `busy` high exactly 32 cycles, then `done` pulse with `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`. `Y` unchanged. A `start` issued mid-CALC is ignored.
- **Divide cases:**
  - DIV A=0xFFFFFFF9, B=2 → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF` after 32 busy cycles.
  - DIV A=0x80000000, B=0xFFFFFFFF → `lo=0x80000000`, `hi=0`.
  - DIVU A=5, B=0 → `done` next cycle, `lo=0xFFFFFFFF`, `hi=5`, `busy` never high.
- **Reset abort:** assert `rst` during CALC iteration 10 → next cycle `busy=0`, `done=0`, `hi=lo=Y=0`, all flags 0. A new ADD issued afterward completes normally.
